// File: rtl/debug_snapshot_streamer.sv
// rtl/debug_snapshot_streamer.sv - sweeps the debug mux into a word buffer and streams it as a byte frame
module debug_snapshot_streamer #(
  parameter int         NUM_SEL = 29,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_start,
  output logic [4:0]  DebugSel,
  input  logic [31:0] DebugOutput,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        freeze,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HEADER, S_SEND} state_t;

  localparam logic [4:0] LAST_W = 5'(NUM_SEL - 1);

  state_t      state_q, state_d;
  logic [4:0]  widx_q, widx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [4:0]  sel_q, sel_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        freeze_q, freeze_d;
  logic        done_q, done_d;
  logic        cap_we;
  logic [31:0] rd_word;

  // Snapshot storage; sized for the full 5-bit select space so indexing never goes out of range.
  logic [31:0] snap_q [32];

  // State, counters and all registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      widx_q     <= '0;
      bidx_q     <= '0;
      sel_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      freeze_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      bidx_q     <= bidx_d;
      sel_q      <= sel_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      freeze_q   <= freeze_d;
      done_q     <= done_d;
    end
  end

  // Buffer write: one word per CAPTURE cycle, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      snap_q[widx_q] <= DebugOutput;
    end
  end

  // Next-state and index sequencing; HEADER/SEND always present tx_valid, so tx_ready alone is the handshake.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    cap_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped: restart needs a clean IDLE cycle.
        if (capture_start && !done_q) begin
          state_d = S_CAPTURE;
          widx_d  = '0;
          bidx_d  = '0;
        end
      end
      S_CAPTURE: begin
        cap_we = 1'b1;
        if (widx_q == LAST_W) begin
          state_d = S_HEADER;
          widx_d  = '0;
          bidx_d  = '0;
        end else begin
          widx_d = widx_q + 5'd1;
        end
      end
      S_HEADER: begin
        if (tx_ready) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            if (widx_q == LAST_W) begin
              state_d = S_IDLE;
              widx_d  = '0;
            end else begin
              widx_d = widx_q + 5'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the next state so every output is a flop.
  always_comb begin
    rd_word    = snap_q[widx_d];
    sel_d      = (state_d == S_CAPTURE) ? widx_d : 5'd0;
    tx_valid_d = (state_d == S_HEADER) || (state_d == S_SEND);
    tx_data_d  = 8'd0;
    if (state_d == S_HEADER) begin
      tx_data_d = HEADER;
    end else if (state_d == S_SEND) begin
      tx_data_d = rd_word[{bidx_d, 3'b000} +: 8];
    end
    busy_d   = (state_d != S_IDLE);
    freeze_d = (state_d == S_CAPTURE);
    done_d   = (state_q == S_SEND) && (state_d == S_IDLE);
  end

  assign DebugSel = sel_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign freeze   = freeze_q;
  assign done     = done_q;

endmodule

// File: tb/tb_debug_snapshot_streamer.sv
// tb/tb_debug_snapshot_streamer.sv - directed checks of frame content, timing, backpressure and reset
module tb_debug_snapshot_streamer;

  localparam int N = 29;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        capture_start = 1'b0;
  logic [4:0]  DebugSel;
  logic [31:0] DebugOutput;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy, freeze, done;
  logic        force_ff = 1'b0;

  logic        cs1 = 1'b0;
  logic [4:0]  sel1;
  logic [31:0] dout1;
  logic [7:0]  txd1;
  logic        txv1;
  logic        tx_ready1 = 1'b1;
  logic        busy1, frz1, done1;

  int checks = 0;
  int failures = 0;
  bit ready_mode = 1'b0;
  int run_len = 0;
  int rnd = 0;

  always #5 clk = ~clk;

  assign DebugOutput = force_ff ? 32'hFFFF_FFFF : (32'hC0DE_0000 | {27'd0, DebugSel});
  assign dout1 = 32'h1234_5678 ^ {27'd0, sel1};

  debug_snapshot_streamer #(.NUM_SEL(N), .HEADER(8'hA5)) dut (
    .clk(clk), .reset(reset), .capture_start(capture_start),
    .DebugSel(DebugSel), .DebugOutput(DebugOutput),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .freeze(freeze), .done(done)
  );

  debug_snapshot_streamer #(.NUM_SEL(1), .HEADER(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .capture_start(cs1),
    .DebugSel(sel1), .DebugOutput(dout1),
    .tx_data(txd1), .tx_valid(txv1), .tx_ready(tx_ready1),
    .busy(busy1), .freeze(frz1), .done(done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // tx_ready changes just after each rising edge: steady high, or random with long low runs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!ready_mode) begin
        tx_ready = 1'b1;
      end else if (run_len > 0) begin
        run_len--;
      end else begin
        rnd = $urandom_range(0, 9);
        if (rnd < 2) begin
          tx_ready = 1'b0;
          run_len = $urandom_range(8, 20);
        end else begin
          tx_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  typedef struct {
    bit bp;
    int stray_cap;
    int stray_send;
    bit stray_done;
    bit ff_hdr;
    int exp_len;
    int exp_hdr_cyc;
    int exp_done_cyc;
  } row_t;

  row_t rows[5];

  task automatic run_frame(input row_t r, input string tag);
    logic [7:0] rx[$];
    logic [7:0] exp_b[$];
    logic [31:0] w;
    logic [7:0] prev_data = 8'd0;
    bit prev_stall = 1'b0;
    bit send_fired = 1'b0;
    bit finished = 1'b0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = -1, hdr_cyc = -1, frz_cnt = 0;
    int sel_bad = 0, stab_bad = 0, late_busy = 0, mism = 0;

    exp_b.push_back(8'hA5);
    for (int k = 0; k < N; k++) begin
      w = 32'hC0DE_0000 | k;
      exp_b.push_back(w[7:0]);
      exp_b.push_back(w[15:8]);
      exp_b.push_back(w[23:16]);
      exp_b.push_back(w[31:24]);
    end

    ready_mode = r.bp;
    @(negedge clk);
    capture_start = 1'b1;
    @(negedge clk);
    capture_start = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy), 1);
    check({tag, "_freeze_rise"}, 32'(freeze), 1);
    while (cyc < 4000 && !finished) begin
      if (freeze) begin
        if (DebugSel != frz_cnt[4:0]) sel_bad++;
        frz_cnt++;
      end
      if (tx_valid && hdr_cyc < 0) begin
        hdr_cyc = cyc;
        if (r.ff_hdr) force_ff = 1'b1;
      end
      if (prev_stall && (!tx_valid || tx_data != prev_data)) stab_bad++;
      if (tx_valid && tx_ready) rx.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (done_cnt > 0 && !done && busy) late_busy++;
      capture_start = 1'b0;
      if (cyc == r.stray_cap) capture_start = 1'b1;
      if (!send_fired && r.stray_send >= 0 && rx.size() == r.stray_send) begin
        capture_start = 1'b1;
        send_fired = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (r.stray_done) capture_start = 1'b1;
      end
      if (done_cnt > 0 && cyc >= done_cyc + 6) finished = 1'b1;
      @(negedge clk);
      cyc++;
    end
    capture_start = 1'b0;
    force_ff = 1'b0;
    ready_mode = 1'b0;

    check({tag, "_finished"}, 32'(finished), 1);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_freeze_cycles"}, frz_cnt, N);
    check({tag, "_sel_seq_bad"}, sel_bad, 0);
    check({tag, "_hdr_cycle"}, hdr_cyc, r.exp_hdr_cyc);
    if (r.exp_done_cyc >= 0) check({tag, "_done_cycle"}, done_cyc, r.exp_done_cyc);
    check({tag, "_stall_unstable"}, stab_bad, 0);
    check({tag, "_busy_after_done"}, late_busy, 0);
    check({tag, "_frame_len"}, rx.size(), r.exp_len);
    for (int i = 0; i < exp_b.size() && i < rx.size(); i++) begin
      if (rx[i] !== exp_b[i]) mism++;
    end
    check({tag, "_byte_mismatches"}, mism, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int guard;
    int cyc;
    int f1_frz, f1_done, f1_done_cyc, f1_hdr_cyc;
    logic [7:0] rx1[$];
    logic [7:0] exp1[5];

    rows[0] = '{bp: 1'b0, stray_cap: -1, stray_send: -1, stray_done: 1'b0, ff_hdr: 1'b0,
                exp_len: 1 + 4 * N, exp_hdr_cyc: N, exp_done_cyc: N + 1 + 4 * N};
    rows[1] = '{bp: 1'b1, stray_cap: -1, stray_send: -1, stray_done: 1'b0, ff_hdr: 1'b0,
                exp_len: 1 + 4 * N, exp_hdr_cyc: N, exp_done_cyc: -1};
    rows[2] = '{bp: 1'b0, stray_cap: 10, stray_send: 50, stray_done: 1'b1, ff_hdr: 1'b0,
                exp_len: 1 + 4 * N, exp_hdr_cyc: N, exp_done_cyc: N + 1 + 4 * N};
    rows[3] = '{bp: 1'b1, stray_cap: 5, stray_send: 80, stray_done: 1'b1, ff_hdr: 1'b1,
                exp_len: 1 + 4 * N, exp_hdr_cyc: N, exp_done_cyc: -1};
    rows[4] = '{bp: 1'b0, stray_cap: -1, stray_send: -1, stray_done: 1'b0, ff_hdr: 1'b1,
                exp_len: 1 + 4 * N, exp_hdr_cyc: N, exp_done_cyc: N + 1 + 4 * N};

    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_freeze", 32'(freeze), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sel", 32'(DebugSel), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_sel", 32'(DebugSel), 0);
    check("idle_valid", 32'(tx_valid), 0);

    for (int i = 0; i < 5; i++) begin
      run_frame(rows[i], $sformatf("row%0d", i));
    end

    // Reset asserted between edges once 40 bytes of a frame have gone out.
    @(negedge clk);
    capture_start = 1'b1;
    @(negedge clk);
    capture_start = 1'b0;
    cnt = 0;
    guard = 0;
    while (cnt < 40 && guard < 500) begin
      if (tx_valid && tx_ready) cnt++;
      @(negedge clk);
      guard++;
    end
    check("midrst_reached_40", cnt, 40);
    check("midrst_valid_before", 32'(tx_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx_valid", 32'(tx_valid), 0);
    check("midrst_tx_data", 32'(tx_data), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_freeze", 32'(freeze), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_sel", 32'(DebugSel), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(rows[0], "post_rst");

    // Single-select instance: A5 then the word seen at select 0, little-endian.
    exp1[0] = 8'hA5;
    exp1[1] = 8'h78;
    exp1[2] = 8'h56;
    exp1[3] = 8'h34;
    exp1[4] = 8'h12;
    f1_frz = 0;
    f1_done = 0;
    f1_done_cyc = -1;
    f1_hdr_cyc = -1;
    @(negedge clk);
    cs1 = 1'b1;
    @(negedge clk);
    cs1 = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      if (frz1) f1_frz++;
      if (txv1 && f1_hdr_cyc < 0) f1_hdr_cyc = cyc;
      if (txv1 && tx_ready1) rx1.push_back(txd1);
      if (done1) begin
        f1_done++;
        f1_done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    check("n1_freeze_cycles", f1_frz, 1);
    check("n1_done_count", f1_done, 1);
    check("n1_hdr_cycle", f1_hdr_cyc, 1);
    check("n1_done_cycle", f1_done_cyc, 6);
    check("n1_frame_len", rx1.size(), 5);
    for (int i = 0; i < 5 && i < rx1.size(); i++) begin
      check($sformatf("n1_byte%0d", i), 32'(rx1[i]), 32'(exp1[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
